au_sequencer: RTL and testbench

Drives the AU register-loading interface from clocked logic in place of pushbuttons. On a start request it places operand A and then operand B on the shared operand bus, strobes each active-low load line, and selects add or subtract. It then waits for the adder to settle, strobes the result register, and captures result/OVR/Cout into its own output registers. It sits between the top-level control or test logic and the AU.

---
 rtl/au_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_au_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/au_sequencer.sv
// Loads A then B onto the AU over the shared operand bus, strobes LoadR, then captures result/OVR/Cout.
// done pulses 2*SETUP_CYCLES+SETTLE_CYCLES+7 edges after start is sampled; start is ignored while busy.
module au_sequencer #(
    parameter int WIDTH         = 8,
    parameter int SETUP_CYCLES  = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] au_result,
    input  logic             au_ovr,
    input  logic             au_cout,
    output logic [WIDTH-1:0] BIT_Input,
    output logic             LoadA,
    output logic             LoadB,
    output logic             LoadR,
    output logic             ADDSUB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_q,
    output logic             ovr_q,
    output logic             cout_q
);

    localparam int CNT_MAX  = (SETUP_CYCLES > SETTLE_CYCLES) ? SETUP_CYCLES : SETTLE_CYCLES;
    localparam int CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int SETTLE_N = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES : 1;

    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_N - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP_A,
        S_STROBE_A,
        S_HOLD_A,
        S_SETUP_B,
        S_STROBE_B,
        S_HOLD_B,
        S_SETTLE,
        S_STROBE_R,
        S_HOLD_R,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               sub_q;
    logic               accept;

    logic [WIDTH-1:0]   bus_d;
    logic               load_a_d, load_b_d, load_r_d;
    logic               addsub_d, busy_d, done_d;

    assign accept = (state_q == S_IDLE) && start;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                a_q   <= op_a;
                b_q   <= op_b;
                sub_q <= sub;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) state_d = S_SETUP_A;
            end
            S_SETUP_A: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE_A;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STROBE_A: state_d = S_HOLD_A;
            S_HOLD_A:   state_d = S_SETUP_B;
            S_SETUP_B: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE_B;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STROBE_B: state_d = S_HOLD_B;
            S_HOLD_B:   state_d = (SETTLE_CYCLES == 0) ? S_STROBE_R : S_SETTLE;
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_STROBE_R;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STROBE_R: state_d = S_HOLD_R;
            S_HOLD_R:   state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ADDSUB and busy assert on the accepting edge so they cover the whole operation.
    always_comb begin
        bus_d    = '0;
        load_a_d = 1'b1;
        load_b_d = 1'b1;
        load_r_d = 1'b1;
        addsub_d = sub_q;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                addsub_d = accept ? sub : 1'b0;
                busy_d   = accept;
            end
            S_SETUP_A, S_HOLD_A: bus_d = a_q;
            S_STROBE_A: begin
                bus_d    = a_q;
                load_a_d = 1'b0;
            end
            S_SETUP_B, S_HOLD_B, S_SETTLE, S_HOLD_R: bus_d = b_q;
            S_STROBE_B: begin
                bus_d    = b_q;
                load_b_d = 1'b0;
            end
            S_STROBE_R: begin
                bus_d    = b_q;
                load_r_d = 1'b0;
            end
            S_DONE: begin
                bus_d  = b_q;
                done_d = 1'b1;
            end
            default: begin
                addsub_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            BIT_Input <= '0;
            LoadA     <= 1'b1;
            LoadB     <= 1'b1;
            LoadR     <= 1'b1;
            ADDSUB    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_q  <= '0;
            ovr_q     <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            BIT_Input <= bus_d;
            LoadA     <= load_a_d;
            LoadB     <= load_b_d;
            LoadR     <= load_r_d;
            ADDSUB    <= addsub_d;
            busy      <= busy_d;
            done      <= done_d;
            if (state_q == S_DONE) begin
                result_q <= au_result;
                ovr_q    <= au_ovr;
                cout_q   <= au_cout;
            end
        end
    end

endmodule

// File: tb/tb_au_sequencer.sv
// Scoreboarded bench: default-parameter sequencer plus a SETUP_CYCLES=3 / SETTLE_CYCLES=0 instance, each driving a behavioural AU.
module tb_au_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr_n;
    logic       start, sub, start6, sub6;
    logic [7:0] op_a, op_b, op_a6, op_b6;

    logic [7:0] au_res  = 8'h00, au_res6  = 8'h00;
    logic       au_ovr  = 1'b0,  au_ovr6  = 1'b0;
    logic       au_cout = 1'b0,  au_cout6 = 1'b0;
    logic [7:0] au_a = 8'h00, au_b = 8'h00, au_a6 = 8'h00, au_b6 = 8'h00;

    logic [7:0] bus, bus6, res_q, res_q6;
    logic       load_a, load_b, load_r, addsub, busy, done, ovr_q, cout_q;
    logic       load_a6, load_b6, load_r6, addsub6, busy6, done6, ovr_q6, cout_q6;

    au_sequencer u_dut (
        .CLK(clk), .CLR(clr_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
        .au_result(au_res), .au_ovr(au_ovr), .au_cout(au_cout),
        .BIT_Input(bus), .LoadA(load_a), .LoadB(load_b), .LoadR(load_r), .ADDSUB(addsub),
        .busy(busy), .done(done), .result_q(res_q), .ovr_q(ovr_q), .cout_q(cout_q)
    );

    au_sequencer #(.WIDTH(8), .SETUP_CYCLES(3), .SETTLE_CYCLES(0)) u_dut6 (
        .CLK(clk), .CLR(clr_n), .start(start6), .sub(sub6), .op_a(op_a6), .op_b(op_b6),
        .au_result(au_res6), .au_ovr(au_ovr6), .au_cout(au_cout6),
        .BIT_Input(bus6), .LoadA(load_a6), .LoadB(load_b6), .LoadR(load_r6), .ADDSUB(addsub6),
        .busy(busy6), .done(done6), .result_q(res_q6), .ovr_q(ovr_q6), .cout_q(cout_q6)
    );

    // Behavioural AU: registers load on the falling edge of their load lines.
    function automatic logic [9:0] au_calc(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] bx;
        logic [8:0] sum;
        bx  = s ? ~b : b;
        sum = {1'b0, a} + {1'b0, bx} + {8'd0, s};
        return {sum[8], (a[7] == bx[7]) && (sum[7] != a[7]), sum[7:0]};
    endfunction

    always @(negedge load_a) au_a = bus;
    always @(negedge load_b) au_b = bus;
    always @(negedge load_r) {au_cout, au_ovr, au_res} = au_calc(au_a, au_b, addsub);
    always @(negedge load_a6) au_a6 = bus6;
    always @(negedge load_b6) au_b6 = bus6;
    always @(negedge load_r6) {au_cout6, au_ovr6, au_res6} = au_calc(au_a6, au_b6, addsub6);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] res;
        logic       ovr;
        logic       cout;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp6_q[$];
    exp_t mon_e, mon_e6;
    logic [7:0] h6 [3];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (clr_n) begin
            if ($countones({~load_a, ~load_b, ~load_r}) != 0)
                chk("one_load_low", $countones({~load_a, ~load_b, ~load_r}), 1);
            if (exp_q.size() > 0) begin
                if (!load_a) chk("bus_at_loada", bus, exp_q[0].a);
                if (!load_b) chk("bus_at_loadb", bus, exp_q[0].b);
                if (busy)    chk("addsub_during_op", addsub, exp_q[0].s);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done=1, expected no pulse at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result_q", res_q, mon_e.res);
                    chk("ovr_q", ovr_q, mon_e.ovr);
                    chk("cout_q", cout_q, mon_e.cout);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (clr_n) begin
            if ($countones({~load_a6, ~load_b6, ~load_r6}) != 0)
                chk("one_load_low6", $countones({~load_a6, ~load_b6, ~load_r6}), 1);
            if (exp6_q.size() > 0) begin
                if (!load_a6) begin
                    chk("bus6_at_loada", bus6, exp6_q[0].a);
                    for (int i = 0; i < 3; i++) chk("bus6_setup_a", h6[i], exp6_q[0].a);
                end
                if (!load_b6) begin
                    chk("bus6_at_loadb", bus6, exp6_q[0].b);
                    for (int i = 0; i < 3; i++) chk("bus6_setup_b", h6[i], exp6_q[0].b);
                end
            end
            if (done6) begin
                if (exp6_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done6_unexpected: got done=1, expected no pulse at %0t", $time);
                end else begin
                    mon_e6 = exp6_q.pop_front();
                    chk("result_q6", res_q6, mon_e6.res);
                    chk("ovr_q6", ovr_q6, mon_e6.ovr);
                    chk("cout_q6", cout_q6, mon_e6.cout);
                end
            end
        end
        h6[2] = h6[1];
        h6[1] = h6[0];
        h6[0] = bus6;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [7:0] r, input logic v, input logic c, input bit poke);
        exp_t e;
        int   n;
        logic busy_ok;
        e.a = a; e.b = b; e.s = s; e.res = r; e.ovr = v; e.cout = c;
        exp_q.push_back(e);
        op_a = a; op_b = b; sub = s; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            tick();
            n++;
            if (poke && n == 3) start = 1'b1;
            if (poke && n == 4) start = 1'b0;
            if (!busy) busy_ok = 1'b0;
        end
        chk("latency", n, 11);
        chk("busy_continuous", busy_ok, 1'b1);
        tick();
        chk("done_one_cycle", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk("addsub_idle", addsub, 1'b0);
        chk("bus_idle", bus, 8'h00);
    endtask

    task automatic run_op6(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic [7:0] r, input logic v, input logic c);
        exp_t e;
        int   n;
        e.a = a; e.b = b; e.s = s; e.res = r; e.ovr = v; e.cout = c;
        exp6_q.push_back(e);
        op_a6 = a; op_b6 = b; sub6 = s; start6 = 1'b1;
        tick();
        start6 = 1'b0;
        n = 0;
        while (!done6 && n < 40) begin
            tick();
            n++;
        end
        chk("latency6", n, 13);
        tick();
        chk("done6_one_cycle", done6, 1'b0);
    endtask

    initial begin
        int k;
        clr_n = 1'b1;
        start = 1'b0; sub = 1'b0; op_a = 8'h00; op_b = 8'h00;
        start6 = 1'b0; sub6 = 1'b0; op_a6 = 8'h00; op_b6 = 8'h00;
        #3 clr_n = 1'b0;
        #3;
        chk("rst_loads", {load_a, load_b, load_r}, 3'b111);
        chk("rst_bus", bus, 8'h00);
        chk("rst_ctrl", {addsub, busy, done}, 3'b000);
        chk("rst_capture", {res_q, ovr_q, cout_q}, 10'h000);
        chk("rst_loads6", {load_a6, load_b6, load_r6, busy6}, 4'b1110);
        repeat (2) tick();
        clr_n = 1'b1;
        tick();

        run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op(8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        run_op(8'h0A, 8'h14, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b1);

        // Abort during the LoadB strobe, then a clean operation.
        begin
            exp_t e;
            e.a = 8'h11; e.b = 8'h22; e.s = 1'b0; e.res = 8'h33; e.ovr = 1'b0; e.cout = 1'b0;
            exp_q.push_back(e);
            op_a = 8'h11; op_b = 8'h22; sub = 1'b0; start = 1'b1;
            tick();
            start = 1'b0;
            k = 0;
            while (load_b && k < 20) begin
                tick();
                k++;
            end
            chk("saw_loadb_low", load_b, 1'b0);
            #1 clr_n = 1'b0;
            #1;
            chk("abort_loadb", load_b, 1'b1);
            chk("abort_busy", busy, 1'b0);
            chk("abort_bus", bus, 8'h00);
            chk("abort_loads", {load_a, load_r, done}, 3'b110);
            chk("abort_result", res_q, 8'h00);
            void'(exp_q.pop_back());
            repeat (2) tick();
            clr_n = 1'b1;
            repeat (15) tick();
            chk("abort_no_done", done, 1'b0);
        end
        run_op(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);

        run_op6(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op6(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size() + exp6_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
